// File: rtl/pentary_icache_if.sv
// rtl/pentary_icache_if.sv - fetch and refill bus bundle for pentary_icache
interface pentary_icache_if;
    logic [47:0] i_cache_addr;
    logic        i_cache_read;
    logic [31:0] i_cache_data;
    logic        i_cache_ready;
    logic        mem_req;
    logic [47:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    modport slave (
        input  i_cache_addr,
        input  i_cache_read,
        output i_cache_data,
        output i_cache_ready,
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport master (
        output i_cache_addr,
        output i_cache_read,
        input  i_cache_data,
        input  i_cache_ready,
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/pentary_icache.sv
// rtl/pentary_icache.sv - direct-mapped one-word-per-line instruction cache
module pentary_icache #(
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pentary_icache_if.slave        bus,
    input  logic                   invalidate,
    output logic                   busy,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 46 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        INVAL
    } state_t;

    state_t state;
    state_t state_next;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic             inval_pending;
    logic [IDX_W-1:0] sweep;
    logic [47:2]      refill_addr;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             lookup_hit;
    logic             hit;
    logic             miss;
    logic             fill;
    logic             unused_ok;

    assign req_idx    = bus.i_cache_addr[IDX_W+1:2];
    assign req_tag    = bus.i_cache_addr[47:IDX_W+2];
    assign fill_idx   = refill_addr[IDX_W+1:2];
    assign fill_tag   = refill_addr[47:IDX_W+2];
    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_ok  = ^bus.i_cache_addr[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Invalidation outranks a same-cycle miss; a hit is still served since its data is good.
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        miss       = 1'b0;
        fill       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_cache_read && lookup_hit) begin
                    hit = 1'b1;
                end
                if (invalidate) begin
                    state_next = INVAL;
                end else if (bus.i_cache_read && !lookup_hit) begin
                    miss       = 1'b1;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                if (bus.mem_ack) begin
                    fill       = 1'b1;
                    state_next = (inval_pending || invalidate) ? INVAL : IDLE;
                end
            end
            INVAL: begin
                if (sweep == IDX_W'(LINES - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.i_cache_ready = hit;
    assign bus.i_cache_data  = hit ? data_mem[req_idx] : 32'd0;
    assign bus.mem_req       = (state == REFILL);
    assign bus.mem_addr      = {refill_addr, 2'b00};
    assign busy              = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (fill) begin
            valid[fill_idx] <= 1'b1;
        end else if (state == INVAL) begin
            valid[sweep] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= bus.mem_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sweep <= '0;
        end else if (state == INVAL) begin
            sweep <= sweep + 1'b1;
        end else begin
            sweep <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inval_pending <= 1'b0;
        end else if (state == REFILL) begin
            if (bus.mem_ack) begin
                inval_pending <= 1'b0;
            end else if (invalidate) begin
                inval_pending <= 1'b1;
            end
        end else begin
            inval_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refill_addr <= '0;
        end else if (miss) begin
            refill_addr <= bus.i_cache_addr[47:2];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (hit && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pentary_icache.sv
// tb/tb_pentary_icache.sv - self-checking bench for pentary_icache
module tb_pentary_icache;
    logic        clk;
    logic        reset_n;
    logic        invalidate;
    logic        busy;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    pentary_icache_if bus ();

    pentary_icache #(.IDX_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .invalidate (invalidate),
        .busy       (busy),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one word per line, index addr[5:2], tag addr[47:6]
    bit          m_valid [16];
    logic [41:0] m_tag   [16];
    logic [31:0] m_data  [16];
    logic [15:0] m_hits;
    logic [15:0] m_miss;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits = 16'd0;
        m_miss = 16'd0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic hit_inc();
        if (m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
    endtask

    task automatic miss_inc();
        if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
    endtask

    function automatic bit model_hit(input logic [47:0] a);
        return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[47:6]);
    endfunction

    task automatic model_fill(input logic [47:0] a, input logic [31:0] d);
        m_valid[a[5:2]] = 1'b1;
        m_tag[a[5:2]]   = a[47:6];
        m_data[a[5:2]]  = d;
    endtask

    task automatic fetch(input logic [47:0] a, input int ack_wait, input logic [31:0] d);
        bus.i_cache_addr = a;
        bus.i_cache_read = 1'b1;
        #1;
        if (model_hit(a)) begin
            check("hit_ready", bus.i_cache_ready, 1'b1);
            check("hit_data", bus.i_cache_data, m_data[a[5:2]]);
            hit_inc();
            step();
        end else begin
            check("miss_ready", bus.i_cache_ready, 1'b0);
            miss_inc();
            step();
            check("refill_req", bus.mem_req, 1'b1);
            check("refill_addr", bus.mem_addr, {a[47:2], 2'b00});
            for (int i = 0; i < ack_wait; i++) begin
                step();
                check("refill_hold", bus.mem_req, 1'b1);
            end
            bus.mem_ack  = 1'b1;
            bus.mem_data = d;
            step();
            bus.mem_ack  = 1'b0;
            model_fill(a, d);
            check("refill_then_ready", bus.i_cache_ready, 1'b1);
            check("refill_then_data", bus.i_cache_data, d);
            hit_inc();
            step();
        end
        bus.i_cache_read = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hits"}, hit_count, m_hits);
        check({tag, "_miss"}, miss_count, m_miss);
    endtask

    // Current cycle is the first INVAL cycle; the sweep must last exactly 16 cycles.
    task automatic expect_inval(input int poke_at);
        for (int i = 0; i < 16; i++) begin
            check("inval_busy", busy, 1'b1);
            check("inval_no_ready", bus.i_cache_ready, 1'b0);
            invalidate = (i == poke_at);
            step();
        end
        invalidate = 1'b0;
        check("inval_done", busy, 1'b0);
        model_clear();
    endtask

    initial begin
        logic [47:0] a;
        logic [31:0] d;
        int          n;

        reset_n          = 1'b0;
        invalidate       = 1'b0;
        bus.i_cache_addr = 48'h40;
        bus.i_cache_read = 1'b1;
        bus.mem_ack      = 1'b0;
        bus.mem_data     = 32'h0;
        model_reset();
        repeat (2) step();
        check("rst_ready", bus.i_cache_ready, 1'b0);
        check("rst_data", bus.i_cache_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 48'h0);
        check_counts("rst");
        bus.i_cache_read = 1'b0;
        reset_n = 1'b1;
        step();

        // Cold miss, ack after 3 cycles
        fetch(48'h40, 3, 32'hDEADBEEF);
        check("cold_miss_count", miss_count, 16'd1);
        check("cold_hit_count", hit_count, 16'd1);

        // Conflict on index 0
        fetch(48'h80, 1, $urandom);
        fetch(48'h40, 0, $urandom);
        check("conflict_miss_count", miss_count, 16'd3);
        check_counts("conflict");

        // Random fetch traffic
        for (int k = 0; k < 60; k++) begin
            a = 48'h0;
            a[5:0]  = 6'($urandom_range(0, 63));
            a[7:6]  = 2'($urandom_range(0, 3));
            a[47]   = 1'($urandom_range(0, 1));
            fetch(a, $urandom_range(0, 3), $urandom);
        end
        check_counts("random");

        // Stray ack in IDLE is ignored
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'h12345678;
        step();
        bus.mem_ack  = 1'b0;
        check("stray_ack_busy", busy, 1'b0);
        check_counts("stray_ack");
        for (int k = 0; k < 16; k++) fetch({40'h0, 2'($urandom_range(0, 3)), 4'(k), 2'b00}, 0, $urandom);
        check_counts("after_stray");

        // Invalidate in IDLE, with a second pulse during the sweep
        invalidate = 1'b1;
        step();
        expect_inval(4);
        fetch(48'h40, 0, 32'hA5A5A5A5);

        // Invalidate together with a miss request
        bus.i_cache_addr = 48'h2C0;
        bus.i_cache_read = 1'b1;
        invalidate = 1'b1;
        #1;
        check("inv_miss_ready", bus.i_cache_ready, 1'b0);
        step();
        invalidate = 1'b0;
        bus.i_cache_read = 1'b0;
        check("inv_miss_no_req", bus.mem_req, 1'b0);
        expect_inval(-1);
        check_counts("inv_priority");

        // Invalidate while waiting for the refill ack
        bus.i_cache_addr = 48'h40;
        bus.i_cache_read = 1'b1;
        #1;
        check("inv_refill_ready", bus.i_cache_ready, 1'b0);
        miss_inc();
        step();
        bus.i_cache_read = 1'b0;
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        check("inv_refill_hold", bus.mem_req, 1'b1);
        d = $urandom;
        bus.mem_ack  = 1'b1;
        bus.mem_data = d;
        step();
        bus.mem_ack = 1'b0;
        model_fill(48'h40, d);
        check("inv_refill_req_drop", bus.mem_req, 1'b0);
        expect_inval(-1);
        fetch(48'h40, 2, $urandom);
        check_counts("inv_refill");

        // Address changes during refill; latched address is filled
        bus.i_cache_addr = 48'h44;
        bus.i_cache_read = 1'b1;
        #1;
        miss_inc();
        step();
        bus.i_cache_addr = 48'h100;
        bus.i_cache_read = 1'b0;
        check("addr_change_latched", bus.mem_addr, 48'h44);
        step();
        check("addr_change_latched2", bus.mem_addr, 48'h44);
        d = $urandom;
        bus.mem_ack  = 1'b1;
        bus.mem_data = d;
        step();
        bus.mem_ack = 1'b0;
        model_fill(48'h44, d);
        check("addr_change_idle", busy, 1'b0);
        fetch(48'h44, 0, $urandom);
        fetch(48'h100, 1, $urandom);
        check_counts("addr_change");

        // Reset mid-refill
        bus.i_cache_addr = 48'h80;
        bus.i_cache_read = 1'b1;
        #1;
        step();
        bus.i_cache_read = 1'b0;
        check("pre_reset_req", bus.mem_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_req_drop", bus.mem_req, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_addr", bus.mem_addr, 48'h0);
        model_reset();
        check_counts("reset_async");
        step();
        reset_n = 1'b1;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 32'hBADC0DE5;
        step();
        bus.mem_ack = 1'b0;
        check("late_ack_busy", busy, 1'b0);
        check_counts("late_ack");
        fetch(48'h80, 0, 32'h0BADF00D);
        check("post_reset_miss", miss_count, 16'd1);

        // Hit counter saturation
        bus.i_cache_addr = 48'h80;
        bus.i_cache_read = 1'b1;
        #1;
        check("sat_hit_ready", bus.i_cache_ready, 1'b1);
        n = 65534 - int'(m_hits);
        for (int k = 0; k < n; k++) begin
            hit_inc();
            step();
        end
        check("sat_fffe", hit_count, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            hit_inc();
            step();
        end
        check("sat_ffff", hit_count, 16'hFFFF);
        check_counts("sat");
        bus.i_cache_read = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
